add_bcd_sched: RTL and testbench

Two-requester scheduler for the shared 4-bit CLA adder + binary-to-BCD converter datapath. Each requester submits an operand pair (A, B, Cin) with a valid/ready handshake. The block arbitrates round-robin, drives the adder, zero-extends its 5-bit sum to 12 bits and starts the converter. It waits for the converter's ready rising edge and returns the 16-bit BCD result, tagged with the requester ID, on a valid/ready output port.

---
 rtl/add_bcd_sched.sv | 202 ++++++++++++++++++++
 tb/tb_add_bcd_sched.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/add_bcd_sched.sv
// add_bcd_sched: two-requester round-robin scheduler that feeds a shared
// 4-bit adder and a binary-to-BCD converter. It returns the tagged BCD
// result on a valid/ready port.
// Optional feature macro: ADD_BCD_SCHED_TIMEOUT_EN adds a WAIT watchdog.
// The watchdog aborts after TIMEOUT_CYCLES and flags the result with res_err.
module add_bcd_sched #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req0_valid,
  input  logic [3:0]  i_req0_a,
  input  logic [3:0]  i_req0_b,
  input  logic        i_req0_cin,
  input  logic        i_req1_valid,
  input  logic [3:0]  i_req1_a,
  input  logic [3:0]  i_req1_b,
  input  logic        i_req1_cin,
  output logic        o_req0_ready,
  output logic        o_req1_ready,
  output logic [3:0]  o_add_a,
  output logic [3:0]  o_add_b,
  output logic        o_add_cin,
  input  logic [3:0]  i_add_s,
  input  logic        i_add_cout,
  output logic [11:0] o_conv_bin,
  output logic        o_conv_en,
  input  logic [15:0] i_conv_bcd,
  input  logic        i_conv_rdy,
  output logic        o_res_valid,
  input  logic        i_res_ready,
  output logic [15:0] o_res_bcd,
  output logic        o_res_id,
  output logic        o_res_err,
  output logic [7:0]  o_done_count
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADD  = 3'd1,
    ST_CONV = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_accept;
  logic        w_gnt_id;
  logic        w_rdy_rise;
  logic        w_timeout;

  logic [3:0]  r_add_a;
  logic [3:0]  r_add_b;
  logic        r_add_cin;
  logic [11:0] r_conv_bin;
  logic        r_conv_en;
  logic        r_res_valid;
  logic [15:0] r_res_bcd;
  logic        r_res_id;
  logic [7:0]  r_done_count;
  logic        r_rdy_q;
  logic        r_last_grant;

  // Round-robin pick: on a tie, serve the requester that was not served last.
  assign w_gnt_id   = i_req1_valid & (~i_req0_valid | ~r_last_grant);
  // Only a fresh low-to-high transition counts as converter completion.
  assign w_rdy_rise = i_conv_rdy & ~r_rdy_q;

`ifdef ADD_BCD_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_res_err;

  assign w_timeout = (r_state == ST_WAIT) &&
                     (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) && !w_rdy_rise;

  // WAIT cycle counter: zero outside WAIT, so it is already clear on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (r_state != ST_WAIT) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end
  end

  // Error flag: set by a watchdog abort, cleared by a genuine completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_err <= 1'b0;
    end else if (r_state == ST_WAIT && w_rdy_rise) begin
      r_res_err <= 1'b0;
    end else if (w_timeout) begin
      r_res_err <= 1'b1;
    end
  end

  assign o_res_err = r_res_err;
`else
  assign w_timeout = 1'b0;
  assign o_res_err = 1'b0;
`endif

  // Next-state decode and the same-cycle accept strobe for the grant.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_req0_valid || i_req1_valid) begin
          w_state_nxt = ST_ADD;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ADD:  w_state_nxt = ST_CONV;
      ST_CONV: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (w_rdy_rise || w_timeout) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_DONE: begin
        if (i_res_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The ready pulse must fall in the accept cycle itself, so it is decoded
  // from the registered state rather than registered.
  assign o_req0_ready = w_accept & ~w_gnt_id;
  assign o_req1_ready = w_accept &  w_gnt_id;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered strobes, operand latch, sum capture, result capture and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_add_a      <= 4'd0;
      r_add_b      <= 4'd0;
      r_add_cin    <= 1'b0;
      r_conv_bin   <= 12'd0;
      r_conv_en    <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_bcd    <= 16'd0;
      r_res_id     <= 1'b0;
      r_done_count <= 8'd0;
      r_rdy_q      <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_rdy_q     <= i_conv_rdy;
      r_conv_en   <= (w_state_nxt == ST_CONV);
      r_res_valid <= (w_state_nxt == ST_DONE);
      if (w_accept) begin
        r_add_a      <= w_gnt_id ? i_req1_a   : i_req0_a;
        r_add_b      <= w_gnt_id ? i_req1_b   : i_req0_b;
        r_add_cin    <= w_gnt_id ? i_req1_cin : i_req0_cin;
        r_res_id     <= w_gnt_id;
        r_last_grant <= w_gnt_id;
      end
      if (r_state == ST_ADD) begin
        r_conv_bin <= {7'd0, i_add_cout, i_add_s};
      end
      if (r_state == ST_WAIT && w_rdy_rise) begin
        r_res_bcd <= i_conv_bcd;
      end else if (w_timeout) begin
        r_res_bcd <= 16'd0;
      end
      if (r_state == ST_DONE && i_res_ready) begin
        r_done_count <= r_done_count + 8'd1;
      end
    end
  end

  assign o_add_a      = r_add_a;
  assign o_add_b      = r_add_b;
  assign o_add_cin    = r_add_cin;
  assign o_conv_bin   = r_conv_bin;
  assign o_conv_en    = r_conv_en;
  assign o_res_valid  = r_res_valid;
  assign o_res_bcd    = r_res_bcd;
  assign o_res_id     = r_res_id;
  assign o_done_count = r_done_count;

endmodule

// File: tb/tb_add_bcd_sched.sv
// Directed bench for add_bcd_sched. It plays the adder (combinational sum)
// and drives converter ready/data by hand.
// Define ADD_BCD_SCHED_TIMEOUT_EN to also exercise the watchdog abort.
module tb_add_bcd_sched;

`ifdef ADD_BCD_SCHED_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_cin, req1_valid, req1_cin;
  logic [3:0]  req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic [3:0]  add_a, add_b, add_s;
  logic        add_cin, add_cout;
  logic [11:0] conv_bin;
  logic        conv_en, conv_rdy;
  logic [15:0] conv_bcd;
  logic        res_valid, res_ready, res_id, res_err;
  logic [15:0] res_bcd;
  logic [7:0]  done_count;
  int          n_checks;
  int          n_errors;

  add_bcd_sched #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req0_valid(req0_valid), .i_req0_a(req0_a), .i_req0_b(req0_b), .i_req0_cin(req0_cin),
    .i_req1_valid(req1_valid), .i_req1_a(req1_a), .i_req1_b(req1_b), .i_req1_cin(req1_cin),
    .o_req0_ready(req0_ready), .o_req1_ready(req1_ready),
    .o_add_a(add_a), .o_add_b(add_b), .o_add_cin(add_cin),
    .i_add_s(add_s), .i_add_cout(add_cout),
    .o_conv_bin(conv_bin), .o_conv_en(conv_en),
    .i_conv_bcd(conv_bcd), .i_conv_rdy(conv_rdy),
    .o_res_valid(res_valid), .i_res_ready(res_ready),
    .o_res_bcd(res_bcd), .o_res_id(res_id), .o_res_err(res_err),
    .o_done_count(done_count)
  );

  // External 4-bit adder.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; res_ready = 1'b0; conv_rdy = 1'b0; conv_bcd = 16'h0000;
    req0_valid = 1'b0; req0_a = 4'd0; req0_b = 4'd0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = 4'd0; req1_b = 4'd0; req1_cin = 1'b0;
    tick; tick;
    // Reset state
    chk("rst_req0_ready", req0_ready, 0); chk("rst_conv_en", conv_en, 0);
    chk("rst_res_valid", res_valid, 0);   chk("rst_res_err", res_err, 0);
    chk("rst_add_a", add_a, 0);           chk("rst_add_b", add_b, 0);
    chk("rst_add_cin", add_cin, 0);       chk("rst_conv_bin", conv_bin, 0);
    chk("rst_res_bcd", res_bcd, 0);       chk("rst_res_id", res_id, 0);
    chk("rst_done_count", done_count, 0);
    rst_n = 1'b1;
    tick;

    // Single request 9+7+1 = 17, ready 5 cycles after conv_en
    req0_valid = 1'b1; req0_a = 4'd9; req0_b = 4'd7; req0_cin = 1'b1;
    #1;
    chk("t1_req0_ready", req0_ready, 1); chk("t1_req1_ready", req1_ready, 0);
    tick; req0_valid = 1'b0;
    chk("t1_add_a", add_a, 9); chk("t1_add_b", add_b, 7); chk("t1_add_cin", add_cin, 1);
    chk("t1_ready_pulse", req0_ready, 0);
    tick;
    chk("t1_conv_en", conv_en, 1); chk("t1_conv_bin", conv_bin, 12'h011);
    tick;
    chk("t1_conv_en_pulse", conv_en, 0);
    tick; tick; tick;
    chk("t1_no_early_valid", res_valid, 0);
    tick;
    conv_rdy = 1'b1; conv_bcd = 16'h0017;
    #1;
    chk("t1_valid_same_cycle", res_valid, 0);
    tick;
    chk("t1_res_valid", res_valid, 1); chk("t1_res_bcd", res_bcd, 16'h0017);
    chk("t1_res_id", res_id, 0);       chk("t1_res_err", res_err, 0);
    chk("t1_add_a_hold", add_a, 9);    chk("t1_count_pre", done_count, 0);
    res_ready = 1'b1;
    tick; res_ready = 1'b0;
    chk("t1_valid_drop", res_valid, 0); chk("t1_done_count", done_count, 1);

    // Max operands 15+15+1 = 31 from req1
    req1_valid = 1'b1; req1_a = 4'd15; req1_b = 4'd15; req1_cin = 1'b1;
    #1;
    chk("t2_req1_ready", req1_ready, 1); chk("t2_req0_ready", req0_ready, 0);
    tick; req1_valid = 1'b0; conv_rdy = 1'b0;
    chk("t2_add_a", add_a, 15); chk("t2_add_b", add_b, 15); chk("t2_res_id", res_id, 1);
    tick;
    chk("t2_conv_bin", conv_bin, 12'h01F); chk("t2_add_a_conv", add_a, 15);
    tick;
    chk("t2_add_b_wait", add_b, 15);
    conv_rdy = 1'b1; conv_bcd = 16'h0031;
    tick;
    chk("t2_res_valid", res_valid, 1); chk("t2_res_bcd", res_bcd, 16'h0031);
    chk("t2_res_id_done", res_id, 1);  chk("t2_add_a_done", add_a, 15);
    chk("t2_add_b_done", add_b, 15);
    res_ready = 1'b1;
    tick; res_ready = 1'b0;
    chk("t2_done_count", done_count, 2);

    // Stale ready held high on WAIT entry, then backpressure in DONE
    req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd4; req0_cin = 1'b0;
    #1;
    chk("t3_req0_ready", req0_ready, 1);
    tick; req0_valid = 1'b0;
    tick;
    tick;
    for (int i = 0; i < 4; i++) begin
      chk("t3_stale_ignored", res_valid, 0);
      if (i < 3) tick;
    end
    conv_rdy = 1'b0;
    tick;
    chk("t3_still_wait", res_valid, 0);
    conv_rdy = 1'b1; conv_bcd = 16'h0007;
    tick;
    chk("t3_fresh_edge", res_valid, 1); chk("t3_res_bcd", res_bcd, 16'h0007);
    for (int i = 0; i < 10; i++) begin
      conv_bcd = 16'h9999; conv_rdy = i[0];
      tick;
      chk("t3_bp_valid", res_valid, 1); chk("t3_bp_bcd", res_bcd, 16'h0007);
      chk("t3_bp_id", res_id, 0);       chk("t3_bp_count", done_count, 2);
    end
    res_ready = 1'b1;
    tick; res_ready = 1'b0;
    chk("t3_done_count", done_count, 3); chk("t3_valid_drop", res_valid, 0);

    // Asynchronous reset while in WAIT
    conv_rdy = 1'b0;
    req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd6; req1_cin = 1'b1;
    #1;
    chk("t4_req1_ready", req1_ready, 1);
    tick; req1_valid = 1'b0;
    tick; tick;
    chk("t4_add_a_pre", add_a, 5);
    #2; rst_n = 1'b0; #1;
    chk("t4_conv_en", conv_en, 0);   chk("t4_res_valid", res_valid, 0);
    chk("t4_add_a", add_a, 0);       chk("t4_add_b", add_b, 0);
    chk("t4_add_cin", add_cin, 0);   chk("t4_conv_bin", conv_bin, 0);
    chk("t4_res_id", res_id, 0);     chk("t4_res_bcd", res_bcd, 0);
    chk("t4_res_err", res_err, 0);   chk("t4_done_count", done_count, 0);
    #2; conv_rdy = 1'b1; conv_bcd = 16'h0012;
    #2; rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("t4_late_valid", res_valid, 0); chk("t4_late_conv_en", conv_en, 0);
      chk("t4_late_count", done_count, 0);
    end

    // Contention: both valid, grants alternate starting with req0
    conv_rdy = 1'b0;
    req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd3; req0_cin = 1'b0;
    req1_valid = 1'b1; req1_a = 4'd8; req1_b = 4'd8; req1_cin = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t5_gnt0", req0_ready, (k % 2 == 0) ? 1 : 0);
      chk("t5_gnt1", req1_ready, (k % 2 == 1) ? 1 : 0);
      tick;
      chk("t5_pulse0", req0_ready, 0); chk("t5_pulse1", req1_ready, 0);
      chk("t5_id_add", res_id, k % 2);
      chk("t5_add_a", add_a, (k % 2 == 1) ? 8 : 2);
      tick; tick;
      conv_rdy = 1'b1; conv_bcd = (k % 2 == 1) ? 16'h0016 : 16'h0005;
      tick;
      chk("t5_valid", res_valid, 1); chk("t5_res_id", res_id, k % 2);
      chk("t5_res_bcd", res_bcd, (k % 2 == 1) ? 16'h0016 : 16'h0005);
      res_ready = 1'b1; conv_rdy = 1'b0;
      tick; res_ready = 1'b0;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("t5_done_count", done_count, 4);

`ifdef ADD_BCD_SCHED_TIMEOUT_EN
    // Converter never answers: abort after 8 WAIT cycles
    req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd1; req0_cin = 1'b0;
    #1;
    chk("t6_req0_ready", req0_ready, 1);
    tick; req0_valid = 1'b0;
    tick;
    chk("t6_conv_en", conv_en, 1);
    tick;
    for (int i = 0; i < 8; i++) begin
      chk("t6_wait", res_valid, 0);
      tick;
    end
    chk("t6_valid", res_valid, 1); chk("t6_res_err", res_err, 1);
    chk("t6_res_bcd", res_bcd, 16'h0000);
    res_ready = 1'b1;
    tick; res_ready = 1'b0;
    chk("t6_done_count", done_count, 5);
`else
    chk("t6_res_err_tied", res_err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
